// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm sequencer: FSM state encoding,
// time field widths and the per-slot alarm record.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR   = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MINUTE = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

  typedef struct packed {
    logic              enable;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
  } alarm_slot_t;

  function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                      input logic [MIN_W-1:0]  m);
    return (h <= MAX_HOUR) && (m <= MAX_MINUTE);
  endfunction

endpackage

// File: rtl/alarm_time_counter.sv
// Hour/minute time-of-day counter with load, minute tick and midnight wrap.
// new_minute pulses for one cycle after each tick-driven change only.
module alarm_time_counter
  import alarm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              min_tick,
  input  logic              set_time,
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] cur_hours,
  output logic [MIN_W-1:0]  cur_minutes,
  output logic              new_minute
);

  logic load_ok;

  assign load_ok = set_time && time_valid(hours, minutes);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_hours   <= '0;
      cur_minutes <= '0;
      new_minute  <= 1'b0;
    end else begin
      new_minute <= 1'b0;
      if (load_ok) begin
        cur_hours   <= hours;
        cur_minutes <= minutes;
      end else if (min_tick) begin
        new_minute <= 1'b1;
        if (cur_minutes == MAX_MINUTE) begin
          cur_minutes <= '0;
          cur_hours   <= (cur_hours == MAX_HOUR) ? '0 : cur_hours + 5'd1;
        end else begin
          cur_minutes <= cur_minutes + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: NUM_SLOTS programmable alarms, ring/auto-stop FSM.
// Define ALARM_SNOOZE_EN to build in the snooze input and SNOOZE state.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter  int NUM_SLOTS    = 4,
  parameter  int SNOOZE_MIN   = 5,
  parameter  int RING_MAX_MIN = 10,
  localparam int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              min_tick,
  input  logic              set_time,
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  input  logic              cfg_wr,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [HOUR_W-1:0] cfg_hours,
  input  logic [MIN_W-1:0]  cfg_minutes,
  input  logic              cfg_enable,
  input  logic              snooze,
  input  logic              dismiss,
  output logic [HOUR_W-1:0] cur_hours,
  output logic [MIN_W-1:0]  cur_minutes,
  output logic              alarm_ringing,
  output logic [SLOT_W-1:0] ring_slot
);

  localparam logic [3:0] RING_LAST = 4'(RING_MAX_MIN - 1);

  alarm_state_e      state, state_n;
  logic [3:0]        min_cnt, min_cnt_n;
  logic [SLOT_W-1:0] ring_slot_n;
  logic              new_minute;
  alarm_slot_t       slots [NUM_SLOTS];
  logic              match_any;
  logic [SLOT_W-1:0] match_idx;
  logic              cfg_ok;

  alarm_time_counter u_time (
    .clock       (clock),
    .reset       (reset),
    .min_tick    (min_tick),
    .set_time    (set_time),
    .hours       (hours),
    .minutes     (minutes),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .new_minute  (new_minute)
  );

  assign cfg_ok = cfg_wr && time_valid(cfg_hours, cfg_minutes);

  // Slot table: an index with no backing slot simply matches no loop entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else if (cfg_ok) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cfg_slot == SLOT_W'(i)) begin
          slots[i] <= '{enable: cfg_enable, hours: cfg_hours, minutes: cfg_minutes};
        end
      end
    end
  end

  // Scan high-to-low so the lowest matching index is the one left standing.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots[i].enable && slots[i].hours == cur_hours &&
          slots[i].minutes == cur_minutes) begin
        match_any = 1'b1;
        match_idx = SLOT_W'(i);
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] SNOOZE_LAST = 4'(SNOOZE_MIN - 1);
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    state_n     = state;
    min_cnt_n   = min_cnt;
    ring_slot_n = ring_slot;
    case (state)
      IDLE: begin
        if (new_minute && match_any) begin
          state_n     = RINGING;
          min_cnt_n   = '0;
          ring_slot_n = match_idx;
        end
      end
      RINGING: begin
        if (dismiss) begin
          state_n = IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state_n   = SNOOZE;
          min_cnt_n = '0;
        end
`endif
        else if (min_tick) begin
          if (min_cnt == RING_LAST) begin
            state_n = IDLE;
          end else begin
            min_cnt_n = min_cnt + 4'd1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (dismiss) begin
          state_n = IDLE;
        end else if (min_tick) begin
          if (min_cnt == SNOOZE_LAST) begin
            state_n   = RINGING;
            min_cnt_n = '0;
          end else begin
            min_cnt_n = min_cnt + 4'd1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // alarm_ringing is registered from the next state so it tracks state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      min_cnt       <= '0;
      ring_slot     <= '0;
      alarm_ringing <= 1'b0;
    end else begin
      state         <= state_n;
      min_cnt       <= min_cnt_n;
      ring_slot     <= ring_slot_n;
      alarm_ringing <= (state_n == RINGING);
    end
  end

endmodule
